// File: rtl/hex_command_parser.sv
// hex_command_parser: parses ASCII commands "<a-z><hex digits><CR|LF>" from a
// UART receive byte stream into a command letter and a binary value.
// Optional byte echo to the UART transmitter is enabled by defining
// HEX_COMMAND_PARSER_ECHO_EN; without it tx_data/new_tx_data stay 0.
module hex_command_parser #(
    parameter int WIDTH   = 32,
    parameter int NDIGITS = WIDTH / 4,
    parameter int TIMEOUT = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             new_rx_data,
    output logic [7:0]       cmd,
    output logic [WIDTH-1:0] value,
    output logic [4:0]       ndigits,
    output logic             cmd_valid,
    output logic             cmd_error,
    output logic             busy,
    output logic [7:0]       tx_data,
    output logic             new_tx_data,
    input  logic             tx_busy
);

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_ESC = 8'h1B;

    // Counter wide enough to hold TIMEOUT-1; a 1-bit stub when unused.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        GET_DIGITS,
        ERR_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       pend_cmd_q, pend_cmd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [4:0]       ndigits_q, ndigits_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             cmd_error_q, cmd_error_d;

    logic [4:0]       hex;        // {is_hex, nybble}
    logic             is_eol;
    logic             is_letter;
    logic             tmo_expire;

    // Returns {valid, nybble} for an ASCII hex digit of either case.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = '0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, b[3:0]};
        else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46))
            r = {1'b1, b[3:0] + 4'd9};
        return r;
    endfunction

    // Byte classification and timeout detection; an arriving byte beats expiry.
    always_comb begin
        hex        = hex_decode(rx_data);
        is_eol     = (rx_data == CH_CR) || (rx_data == CH_LF);
        is_letter  = (rx_data >= 8'h61) && (rx_data <= 8'h7A);
        tmo_expire = (TIMEOUT > 0) && (state_q != IDLE) && !new_rx_data &&
                     (tmo_q == TMO_LAST);
    end

    // Next-state and next-output computation for the parser.
    always_comb begin
        state_d     = state_q;
        pend_cmd_d  = pend_cmd_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        value_d     = value_q;
        ndigits_d   = ndigits_q;
        cmd_valid_d = 1'b0;
        cmd_error_d = 1'b0;

        if (new_rx_data || state_q == IDLE)
            tmo_d = '0;
        else
            tmo_d = tmo_q + TW'(1);

        if (new_rx_data) begin
            if (rx_data == CH_ESC) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (is_letter) begin
                            pend_cmd_d = rx_data;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = GET_DIGITS;
                        end
                    end
                    GET_DIGITS: begin
                        if (hex[4]) begin
                            if (cnt_q < 5'(NDIGITS)) begin
                                acc_d = (acc_q << 4) | WIDTH'(hex[3:0]);
                                cnt_d = cnt_q + 5'd1;
                            end else begin
                                state_d = ERR_DRAIN;
                            end
                        end else if (is_eol) begin
                            cmd_d       = pend_cmd_q;
                            value_d     = acc_q;
                            ndigits_d   = cnt_q;
                            cmd_valid_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = ERR_DRAIN;
                        end
                    end
                    ERR_DRAIN: begin
                        if (is_eol) begin
                            cmd_error_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (tmo_expire) begin
            cmd_error_d = 1'b1;
            state_d     = IDLE;
        end
    end

    // Parser state and registered outputs; reset abandons any command silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_cmd_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            cmd_q       <= '0;
            value_q     <= '0;
            ndigits_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_cmd_q  <= pend_cmd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            cmd_q       <= cmd_d;
            value_q     <= value_d;
            ndigits_q   <= ndigits_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_error_q <= cmd_error_d;
        end
    end

    assign cmd       = cmd_q;
    assign value     = value_q;
    assign ndigits   = ndigits_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_error = cmd_error_q;
    assign busy      = (state_q != IDLE);

`ifdef HEX_COMMAND_PARSER_ECHO_EN
    logic [7:0] echo_buf_q, echo_buf_d;
    logic       echo_full_q, echo_full_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       new_tx_q, new_tx_d;
    logic       echo_send;

    // One-byte echo buffer: newest byte overwrites, an error '?' beats both.
    always_comb begin
        echo_send   = echo_full_q && !tx_busy;
        echo_buf_d  = echo_buf_q;
        echo_full_d = echo_full_q && !echo_send;
        tx_data_d   = echo_send ? echo_buf_q : tx_data_q;
        new_tx_d    = echo_send;
        if (new_rx_data) begin
            echo_buf_d  = rx_data;
            echo_full_d = 1'b1;
        end
        if (cmd_error_d) begin
            echo_buf_d  = 8'h3F;
            echo_full_d = 1'b1;
        end
    end

    // Echo buffer and transmit strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_buf_q  <= '0;
            echo_full_q <= 1'b0;
            tx_data_q   <= '0;
            new_tx_q    <= 1'b0;
        end else begin
            echo_buf_q  <= echo_buf_d;
            echo_full_q <= echo_full_d;
            tx_data_q   <= tx_data_d;
            new_tx_q    <= new_tx_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;
    assign tx_data        = '0;
    assign new_tx_data    = 1'b0;
`endif

endmodule

// File: tb/tb_hex_command_parser.sv
// Directed bench for hex_command_parser (WIDTH=32, TIMEOUT=100).
module tb_hex_command_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  cmd;
    logic [31:0] value;
    logic [4:0]  ndigits;
    logic        cmd_valid;
    logic        cmd_error;
    logic        busy;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;

    int checks = 0;
    int errs   = 0;
    int nv = 0, ne = 0, ntx = 0, both = 0;
    int v0, e0, t0, n;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] ESC = 8'h1B;

    hex_command_parser #(.WIDTH(32), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .cmd(cmd), .value(value), .ndigits(ndigits), .cmd_valid(cmd_valid),
        .cmd_error(cmd_error), .busy(busy), .tx_data(tx_data),
        .new_tx_data(new_tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid) nv++;
        if (cmd_error) ne++;
        if (new_tx_data) ntx++;
        if (cmd_valid && cmd_error) both++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (i != s.len() - 1) idle(1);
        end
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0; tx_busy = 1'b0;
        #3;
        chk("rst_cmd", cmd, 0);
        chk("rst_value", value, 0);
        chk("rst_ndigits", ndigits, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_error", cmd_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_new_tx", new_tx_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Full-width command, terminator to strobe is one clock.
        v0 = nv;
        send_str("s1234ABCD"); idle(1); send_byte(CR);
        chk("t1_valid", cmd_valid, 1);
        chk("t1_cmd", cmd, 8'h73);
        chk("t1_value", value, 32'h1234ABCD);
        chk("t1_ndigits", ndigits, 8);
        chk("t1_error", cmd_error, 0);
        idle(1);
        chk("t1_pulse_end", cmd_valid, 0);
        chk("t1_npulse", nv - v0, 1);

        // Nine digits overflow: error, outputs held.
        e0 = ne; v0 = nv;
        send_str("s123456789"); idle(1); send_byte(CR);
        chk("t2_error", cmd_error, 1);
        chk("t2_valid", cmd_valid, 0);
        chk("t2_value_held", value, 32'h1234ABCD);
        idle(1);
        chk("t2_nerr", ne - e0, 1);
        chk("t2_nvalid", nv - v0, 0);

        // Zero-digit command, trailing LF ignored.
        send_str("r"); idle(1); send_byte(CR);
        chk("t3_valid", cmd_valid, 1);
        chk("t3_cmd", cmd, 8'h72);
        chk("t3_value", value, 0);
        chk("t3_ndigits", ndigits, 0);
        idle(1); v0 = nv; e0 = ne;
        send_byte(LF); idle(1);
        chk("t3_busy", busy, 0);
        chk("t3_lf_quiet", (nv - v0) + (ne - e0), 0);

        // Bad character then a good command terminated by LF.
        e0 = ne;
        send_str("sZ1"); idle(1); send_byte(CR);
        chk("t4_error", cmd_error, 1);
        idle(1);
        send_str("tF"); idle(1); send_byte(LF);
        chk("t4_valid", cmd_valid, 1);
        chk("t4_cmd", cmd, 8'h74);
        chk("t4_value", value, 32'hF);
        chk("t4_ndigits", ndigits, 1);
        chk("t4_nerr", ne - e0, 1);

        // Timeout fires 100 cycles after the last byte.
        e0 = ne;
        send_str("s12");
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!cmd_error && n < 150);
        chk("t5_tmo_latency", n, 100);
        chk("t5_busy", busy, 0);
        idle(10);
        chk("t5_nerr", ne - e0, 1);
        send_str("x5"); idle(1); send_byte(CR);
        chk("t5_valid", cmd_valid, 1);
        chk("t5_value", value, 32'h5);

        // Byte arriving on the expiry cycle wins.
        e0 = ne;
        idle(1);
        send_str("q"); idle(99); send_byte(8'h31);
        chk("t6_busy", busy, 1);
        idle(1);
        chk("t6_no_err", ne - e0, 0);
        send_byte(CR);
        chk("t6_valid", cmd_valid, 1);
        chk("t6_value", value, 32'h1);

        // ESC abandons silently.
        idle(1); v0 = nv; e0 = ne;
        send_str("s12"); idle(1); send_byte(ESC);
        chk("t7_busy", busy, 0);
        idle(1); send_byte(CR); idle(2);
        chk("t7_quiet", (nv - v0) + (ne - e0), 0);

        // Asynchronous reset mid-command.
        send_str("s7");
        #2 rst = 1'b1;
        #1;
        chk("t8_rst_cmd", cmd, 0);
        chk("t8_rst_value", value, 0);
        chk("t8_rst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(1); v0 = nv;
        send_byte(CR); idle(1);
        chk("t8_no_valid", nv - v0, 0);
        send_str("k"); idle(1); send_byte(CR);
        chk("t8_recover_cmd", cmd, 8'h6B);
        idle(2);

`ifdef HEX_COMMAND_PARSER_ECHO_EN
        // Held transmitter: only the newest byte survives.
        tx_busy = 1'b1; t0 = ntx;
        send_str("a1"); idle(1); send_byte(CR); idle(2);
        chk("t9_held", ntx - t0, 0);
        tx_busy = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!new_tx_data && n < 10);
        chk("t9_tx_data", tx_data, 8'h0D);
        idle(3);
        chk("t9_ntx", ntx - t0, 1);
`else
        chk("t9_no_tx", ntx, 0);
        chk("t9_tx_data", tx_data, 0);
`endif
        chk("never_both", both, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
